load_store_unit: RTL and testbench

- Memory-access stage directly downstream of aluDecoder.
- Consumes DATAMEMControl (funct3), the ALU result as effective address, and rs2 store data.
- Runs one load or store per request against a ready-handshaked data memory, with byte-lane alignment, load sign/zero extension, and fault detection.
- Stalls the pipeline via busy while a request is outstanding.

---
 rtl/lsu_pkg.sv | 46 ++++
 rtl/load_align.sv | 38 +++
 rtl/load_store_unit.sv | 175 +++++++++++++++++
 tb/tb_load_store_unit.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Load/store unit shared types.
// funct3 codes, FSM states, fault causes and request decode helpers.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE,
        FC_MISALIGN,
        FC_ILLEGAL,
        FC_TIMEOUT
    } fault_cause_t;

    // Stores only have signed-width codes; loads add the unsigned ones.
    function automatic logic f3_illegal(
        input logic       we,
        input logic [2:0] f3
    );
        logic ok;
        ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        if (!we) begin
            ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
        end
        return !ok;
    endfunction

    function automatic logic f3_misaligned(
        input logic [2:0] f3,
        input logic [1:0] off
    );
        logic half;
        half = (f3 == F3_H) || (f3 == F3_HU);
        return (half && off[0]) || ((f3 == F3_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/load_align.sv
// Load data alignment.
// Picks the addressed byte/half of the read word and extends it.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] result
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Lane select followed by sign or zero extension
    always_comb begin
        lane_b = mem_rdata[7:0];
        lane_h = mem_rdata[15:0];
        result = mem_rdata;
        unique case (offset)
            2'd0: lane_b = mem_rdata[7:0];
            2'd1: lane_b = mem_rdata[15:8];
            2'd2: lane_b = mem_rdata[23:16];
            default: lane_b = mem_rdata[31:24];
        endcase
        if (offset[1]) begin
            lane_h = mem_rdata[31:16];
        end
        unique case (funct3)
            F3_B:    result = {{24{lane_b[7]}}, lane_b};
            F3_BU:   result = {24'h0, lane_b};
            F3_H:    result = {{16{lane_h[15]}}, lane_h};
            F3_HU:   result = {16'h0, lane_h};
            default: result = mem_rdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: one memory access per request.
// Handles lane alignment, extension and fault reporting.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  mem_write,
    input  logic [2:0]            DATAMEMControl,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  fault,
    output logic [1:0]            fault_cause,
    output logic [31:0]           rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata
);

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT_CYCLES);

    state_t                state;
    state_t                state_nxt;
    logic [7:0]            cnt;
    logic                  we_q;
    logic [2:0]            f3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic                  fault_q;
    fault_cause_t          cause_q;
    logic [31:0]           load_val;
    logic                  req_ill;
    logic                  req_mis;
    logic                  timeout;

    load_align u_align (
        .mem_rdata (mem_rdata),
        .offset    (addr_q[1:0]),
        .funct3    (f3_q),
        .result    (load_val)
    );

    // Request checks on the live inputs, and the wait-state limit
    always_comb begin
        req_ill = f3_illegal(mem_write, DATAMEMControl);
        req_mis = f3_misaligned(DATAMEMControl, addr[1:0]);
        timeout = !mem_ready && ((cnt + 8'd1) == TO_LIMIT);
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: faults found at start skip the memory phase
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = (req_ill || req_mis) ? DONE : REQ;
                end
            end
            REQ: begin
                if (mem_ready || timeout) begin
                    state_nxt = DONE;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request latch, wait counter, fault status and load result
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= 8'd0;
            we_q    <= 1'b0;
            f3_q    <= 3'b000;
            addr_q  <= '0;
            wdata_q <= 32'h0;
            fault_q <= 1'b0;
            cause_q <= FC_NONE;
            rdata   <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        we_q    <= mem_write;
                        f3_q    <= DATAMEMControl;
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        cnt     <= 8'd0;
                        fault_q <= req_ill || req_mis;
                        if (req_ill) begin
                            cause_q <= FC_ILLEGAL;
                        end else if (req_mis) begin
                            cause_q <= FC_MISALIGN;
                        end else begin
                            cause_q <= FC_NONE;
                        end
                    end
                end
                REQ: begin
                    if (mem_ready) begin
                        if (!we_q) begin
                            rdata <= load_val;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                        if (timeout) begin
                            fault_q <= 1'b1;
                            cause_q <= FC_TIMEOUT;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; memory bus idles at zero
    always_comb begin
        busy        = (state != IDLE);
        done        = 1'b0;
        fault       = 1'b0;
        fault_cause = FC_NONE;
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        mem_addr    = '0;
        mem_be      = 4'b0000;
        mem_wdata   = 32'h0;
        if (state == DONE) begin
            done        = 1'b1;
            fault       = fault_q;
            fault_cause = cause_q;
        end
        if (state == REQ) begin
            mem_req  = 1'b1;
            mem_we   = we_q;
            mem_addr = {addr_q[ADDR_WIDTH-1:2], 2'b00};
            if (we_q) begin
                unique case (f3_q)
                    F3_B: begin
                        mem_be    = 4'b0001 << addr_q[1:0];
                        mem_wdata = {4{wdata_q[7:0]}};
                    end
                    F3_H: begin
                        mem_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                        mem_wdata = {2{wdata_q[15:0]}};
                    end
                    default: begin
                        mem_be    = 4'b1111;
                        mem_wdata = wdata_q;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit.
// Scoreboard of expected completions, one task per scenario.
module tb_load_store_unit;

    typedef struct {
        logic        f;
        logic [1:0]  c;
        logic [31:0] r;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        mem_write;
    logic [2:0]  DATAMEMControl;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [1:0]  fault_cause;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata;

    logic [31:0] rd_word = 32'h0;
    int          wait_states = 0;
    int          req_cyc = 0;

    exp_t        sb[$];
    int          errors = 0;
    int          checks = 0;

    int          got_lat;
    int          got_reqc;
    logic        got_ok;
    logic        got_f;
    logic [1:0]  got_c;
    logic [31:0] got_r;

    load_store_unit #(
        .ADDR_WIDTH     (32),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start          (start),
        .mem_write      (mem_write),
        .DATAMEMControl (DATAMEMControl),
        .addr           (addr),
        .wdata          (wdata),
        .busy           (busy),
        .done           (done),
        .fault          (fault),
        .fault_cause    (fault_cause),
        .rdata          (rdata),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_addr       (mem_addr),
        .mem_be         (mem_be),
        .mem_wdata      (mem_wdata),
        .mem_ready      (mem_ready),
        .mem_rdata      (mem_rdata)
    );

    assign mem_rdata = rd_word;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: ready after wait_states cycles of mem_req
    always @(negedge clk) begin
        if (mem_req) begin
            mem_ready = (req_cyc >= wait_states);
            req_cyc++;
        end else begin
            mem_ready = 1'b0;
            req_cyc = 0;
        end
    end

    task automatic issue(input logic we, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] wd,
                         input exp_t e);
        @(negedge clk);
        mem_write = we;
        DATAMEMControl = f3;
        addr = a;
        wdata = wd;
        start = 1'b1;
        sb.push_back(e);
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        got_lat = 0;
        got_reqc = 0;
        got_ok = 1'b0;
        got_f = 1'b0;
        got_c = 2'b00;
        got_r = 32'h0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if (mem_req) got_reqc++;
            if (done) begin
                got_lat = i;
                got_f = fault;
                got_c = fault_cause;
                got_r = rdata;
                got_ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!got_ok) begin
            errors++;
            $display("FAIL done_wait: no done within %0d cycles", budget);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, fault, mem_req, mem_we, fault_cause, mem_be} !== 10'h0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {busy, done, fault, mem_req, mem_we, fault_cause, mem_be});
        end
        checks++;
        if ({mem_addr, mem_wdata, rdata} !== 96'h0) begin
            errors++;
            $display("FAIL reset_data: addr %h wdata %h rdata %h want 0",
                     mem_addr, mem_wdata, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_loads;
        logic [2:0]  f3s [5];
        logic [31:0] as [5];
        logic [31:0] ws [5];
        logic [31:0] rs [5];
        logic [31:0] mas [5];
        exp_t e;
        f3s = '{3'b010, 3'b000, 3'b100, 3'b101, 3'b001};
        as  = '{32'h2004, 32'h1003, 32'h1003, 32'h2002, 32'h2002};
        ws  = '{32'h11223344, 32'h80FF1234, 32'h80FF1234,
                32'hBEEF0000, 32'hBEEF0000};
        rs  = '{32'h11223344, 32'hFFFFFF80, 32'h00000080,
                32'h0000BEEF, 32'hFFFFBEEF};
        mas = '{32'h2004, 32'h1000, 32'h1000, 32'h2000, 32'h2000};
        wait_states = 0;
        for (int k = 0; k < 5; k++) begin
            rd_word = ws[k];
            issue(1'b0, f3s[k], as[k], 32'h0, '{1'b0, 2'b00, rs[k], 2});
            checks++;
            if ({mem_req, mem_we, mem_be, mem_addr} !== {2'b10, 4'b0000, mas[k]}) begin
                errors++;
                $display("FAIL load%0d_bus: req %b we %b be %b addr %h want 1 0 0000 %h",
                         k, mem_req, mem_we, mem_be, mem_addr, mas[k]);
            end
            wait_done(10);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                    errors++;
                    $display("FAIL load%0d: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                             k, got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
                end
            end
        end
    endtask

    task automatic test_stores;
        logic [2:0]  f3s [3];
        logic [31:0] as [3];
        logic [31:0] wds [3];
        logic [3:0]  bes [3];
        logic [31:0] mws [3];
        logic [31:0] mas [3];
        exp_t e;
        f3s = '{3'b000, 3'b001, 3'b001};
        as  = '{32'h3001, 32'h3002, 32'h3000};
        wds = '{32'h123456AB, 32'h0000CAFE, 32'h1234ABCD};
        bes = '{4'b0010, 4'b1100, 4'b0011};
        mws = '{32'hABABABAB, 32'hCAFECAFE, 32'hABCDABCD};
        mas = '{32'h3000, 32'h3000, 32'h3000};
        wait_states = 0;
        rd_word = 32'h5555AAAA;
        for (int k = 0; k < 3; k++) begin
            issue(1'b1, f3s[k], as[k], wds[k], '{1'b0, 2'b00, 32'hFFFFBEEF, 2});
            checks++;
            if ({mem_req, mem_we, mem_be, mem_wdata, mem_addr} !==
                {2'b11, bes[k], mws[k], mas[k]}) begin
                errors++;
                $display("FAIL store%0d_bus: we %b be %b wdata %h addr %h want 1 %b %h %h",
                         k, mem_we, mem_be, mem_wdata, mem_addr, bes[k], mws[k], mas[k]);
            end
            wait_done(10);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                    errors++;
                    $display("FAIL store%0d: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                             k, got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
                end
            end
        end
    endtask

    task automatic test_wait_states;
        exp_t e;
        wait_states = 3;
        issue(1'b1, 3'b010, 32'h3004, 32'hDEADBEEF, '{1'b0, 2'b00, 32'hFFFFBEEF, 5});
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({mem_req, mem_we, done, mem_be, mem_wdata, mem_addr} !==
                {3'b110, 4'b1111, 32'hDEADBEEF, 32'h3004}) begin
                errors++;
                $display("FAIL sw_wait_c%0d: req %b we %b done %b be %b wdata %h addr %h",
                         k, mem_req, mem_we, done, mem_be, mem_wdata, mem_addr);
            end
            if (k == 2) begin
                addr = 32'hFFFFFFFF;
                wdata = 32'h0;
                mem_write = 1'b0;
                start = 1'b1;
            end
            if (k == 3) start = 1'b0;
            @(posedge clk);
            #1;
        end
        wait_done(10);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (got_lat + 4 !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                errors++;
                $display("FAIL sw_wait: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                         got_lat + 4, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
            end
        end
        wait_states = 0;
    endtask

    task automatic test_faults;
        logic        wes [4];
        logic [2:0]  f3s [4];
        logic [31:0] as [4];
        logic [1:0]  cs [4];
        exp_t e;
        wes = '{1'b0, 1'b0, 1'b1, 1'b1};
        f3s = '{3'b010, 3'b011, 3'b101, 3'b001};
        as  = '{32'h4002, 32'h4000, 32'h4001, 32'h4003};
        cs  = '{2'b01, 2'b10, 2'b10, 2'b01};
        rd_word = 32'h0BAD0BAD;
        for (int k = 0; k < 4; k++) begin
            issue(wes[k], f3s[k], as[k], 32'h77777777,
                  '{1'b1, cs[k], 32'hFFFFBEEF, 1});
            wait_done(10);
            checks++;
            if (got_reqc !== 0) begin
                errors++;
                $display("FAIL fault%0d_req: mem_req cycles %0d want 0", k, got_reqc);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                    errors++;
                    $display("FAIL fault%0d: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                             k, got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
                end
            end
        end
    endtask

    task automatic test_timeout;
        exp_t e;
        wait_states = 1000;
        issue(1'b0, 3'b010, 32'h5000, 32'h0, '{1'b1, 2'b11, 32'hFFFFBEEF, 17});
        wait_done(40);
        checks++;
        if (got_reqc !== 16) begin
            errors++;
            $display("FAIL timeout_req: mem_req cycles %0d want 16", got_reqc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                errors++;
                $display("FAIL timeout: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                         got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
            end
        end
        @(negedge clk);
        checks++;
        if ({busy, done, fault} !== 3'b000) begin
            errors++;
            $display("FAIL timeout_after: busy/done/fault %b want 000", {busy, done, fault});
        end
        wait_states = 0;
    endtask

    task automatic test_back_to_back;
        logic [2:0]  f3s [2];
        logic [31:0] as [2];
        logic [31:0] rs [2];
        exp_t e;
        f3s = '{3'b010, 3'b100};
        as  = '{32'h5000, 32'h5001};
        rs  = '{32'h11223344, 32'h00000033};
        wait_states = 0;
        rd_word = 32'h11223344;
        for (int k = 0; k < 2; k++) begin
            issue(1'b0, f3s[k], as[k], 32'h0, '{1'b0, 2'b00, rs[k], 2});
            wait_done(10);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checks++;
                if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                    errors++;
                    $display("FAIL b2b%0d: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                             k, got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        exp_t e;
        int   seen;
        wait_states = 1000;
        issue(1'b0, 3'b010, 32'h6000, 32'h0, '{1'b0, 2'b00, 32'h0, 2});
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        sb.delete();
        checks++;
        if ({mem_req, busy, done, rdata} !== 35'h0) begin
            errors++;
            $display("FAIL rst_mid: req/busy/done %b rdata %h want 000 0",
                     {mem_req, busy, done}, rdata);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL rst_no_done: done/busy cycles %0d want 0", seen);
        end
        wait_states = 0;
        rd_word = 32'hA5A50001;
        issue(1'b0, 3'b010, 32'h6000, 32'h0, '{1'b0, 2'b00, 32'hA5A50001, 2});
        wait_done(10);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            checks++;
            if (got_lat !== e.lat || got_f !== e.f || got_c !== e.c || got_r !== e.r) begin
                errors++;
                $display("FAIL rst_resume: lat/f/c/rdata %0d/%b/%b/%h want %0d/%b/%b/%h",
                         got_lat, got_f, got_c, got_r, e.lat, e.f, e.c, e.r);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        mem_write = 1'b0;
        DATAMEMControl = 3'b000;
        addr = 32'h0;
        wdata = 32'h0;
        test_reset;
        test_loads;
        test_stores;
        test_wait_states;
        test_faults;
        test_timeout;
        test_back_to_back;
        test_reset_mid;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
